bbox_pixel_walker: RTL and testbench

BBOX_PIXEL_WALKER -- requirements
Module: bbox_pixel_walker

---
 rtl/bbox_pkg.sv | 18 +
 rtl/bbox_clip.sv | 22 ++
 rtl/bbox_pixel_walker.sv | 129 ++++++++++++
 tb/tb_bbox_pixel_walker.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bbox_pkg.sv
// Shared definitions for the bounding-box pixel walker: coordinate format and walker states.
package bbox_pkg;

  localparam int COORD_W   = 16;
  localparam int FRAC_BITS = 6;
  localparam int PIX_ONE   = 64;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } walk_state_e;

  // Truncate a Q10.6 coordinate toward zero onto the pixel grid.
  function automatic logic [COORD_W-1:0] pix_floor(input logic [COORD_W-1:0] v);
    return {v[COORD_W-1:FRAC_BITS], {FRAC_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/bbox_clip.sv
// Combinational screen clip for the bbox walker; clamps the box maxima to the last
// on-screen pixel. Only instantiated when BBOX_WALK_CLIP_EN is defined.
module bbox_clip
  import bbox_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic [COORD_W-1:0] xmax_i,
  input  logic [COORD_W-1:0] ymax_i,
  output logic [COORD_W-1:0] xmax_o,
  output logic [COORD_W-1:0] ymax_o
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'((SCREEN_W - 1) * PIX_ONE);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'((SCREEN_H - 1) * PIX_ONE);

  // A minimum past the limit ends up above the clamped maximum and is dropped upstream.
  assign xmax_o = (xmax_i > X_LIM) ? X_LIM : xmax_i;
  assign ymax_o = (ymax_i > Y_LIM) ? Y_LIM : ymax_i;

endmodule

// File: rtl/bbox_pixel_walker.sv
// Walks every pixel of an axis-aligned box in row-major order over a valid/ready stream.
// Optional screen clipping is enabled with the BBOX_WALK_CLIP_EN macro.
module bbox_pixel_walker
  import bbox_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [COORD_W-1:0] XMIN,
  input  logic [COORD_W-1:0] XMAX,
  input  logic [COORD_W-1:0] YMIN,
  input  logic [COORD_W-1:0] YMAX,
  input  logic               BOX_VALID,
  output logic               BOX_READY,
  output logic [COORD_W-1:0] PX,
  output logic [COORD_W-1:0] PY,
  output logic               PIX_VALID,
  input  logic               PIX_READY,
  output logic               PIX_LAST,
  output logic               BOX_DROP
);

  walk_state_e        state_q, state_d;
  logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [COORD_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
  logic               drop_q, drop_d;

  logic [COORD_W-1:0] cap_xmin, cap_ymin, cap_xmax, cap_ymax;
  logic               accept, degenerate, row_end, col_end;

  assign cap_xmin = pix_floor(XMIN);
  assign cap_ymin = pix_floor(YMIN);

`ifdef BBOX_WALK_CLIP_EN
  bbox_clip #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_clip (
    .xmax_i (pix_floor(XMAX)),
    .ymax_i (pix_floor(YMAX)),
    .xmax_o (cap_xmax),
    .ymax_o (cap_ymax)
  );
`else
  assign cap_xmax = pix_floor(XMAX);
  assign cap_ymax = pix_floor(YMAX);
`endif

  assign BOX_READY  = (state_q == IDLE) && RST_N;
  assign accept     = BOX_VALID && BOX_READY;
  assign degenerate = (cap_xmin > cap_xmax) || (cap_ymin > cap_ymax);

  // Equality compares before incrementing keep boxes near 0xFFC0 from wrapping.
  assign row_end = (px_q == xmax_q);
  assign col_end = (py_q == ymax_q);

  always_comb begin
    state_d = state_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    px_d    = px_q;
    py_d    = py_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          xmin_d = cap_xmin;
          xmax_d = cap_xmax;
          ymin_d = cap_ymin;
          ymax_d = cap_ymax;
          if (degenerate) begin
            drop_d = 1'b1;
          end else begin
            state_d = WALK;
            px_d    = cap_xmin;
            py_d    = cap_ymin;
          end
        end
      end
      WALK: begin
        if (PIX_READY) begin
          if (!row_end) begin
            px_d = px_q + COORD_W'(PIX_ONE);
          end else if (!col_end) begin
            px_d = xmin_q;
            py_d = py_q + COORD_W'(PIX_ONE);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      px_q    <= px_d;
      py_q    <= py_d;
      drop_q  <= drop_d;
    end
  end

  assign PX        = px_q;
  assign PY        = py_q;
  assign PIX_VALID = (state_q == WALK);
  assign PIX_LAST  = PIX_VALID && row_end && col_end;
  assign BOX_DROP  = drop_q;

endmodule

// File: tb/tb_bbox_pixel_walker.sv
// Self-checking bench for bbox_pixel_walker: directed and random boxes against a pixel-list model.
module tb_bbox_pixel_walker;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] XMIN, XMAX, YMIN, YMAX;
  logic        BOX_VALID, BOX_READY;
  logic [15:0] PX, PY;
  logic        PIX_VALID, PIX_READY, PIX_LAST, BOX_DROP;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int x;
    int y;
  } pix_t;
  pix_t exp_q[$];

  always #5 CLK = ~CLK;

  bbox_pixel_walker #(.SCREEN_W(640), .SCREEN_H(480)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .XMIN      (XMIN),
    .XMAX      (XMAX),
    .YMIN      (YMIN),
    .YMAX      (YMAX),
    .BOX_VALID (BOX_VALID),
    .BOX_READY (BOX_READY),
    .PX        (PX),
    .PY        (PY),
    .PIX_VALID (PIX_VALID),
    .PIX_READY (PIX_READY),
    .PIX_LAST  (PIX_LAST),
    .BOX_DROP  (BOX_DROP)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int trunc64(input int v);
    return v - (v % 64);
  endfunction

  // Expected pixel list: every grid point of the truncated (and optionally clipped) box, x fastest.
  task automatic build_model(input int xa_raw, input int xb_raw, input int ya_raw, input int yb_raw);
    int xa, xb, ya, yb;
    exp_q.delete();
    xa = trunc64(xa_raw);
    xb = trunc64(xb_raw);
    ya = trunc64(ya_raw);
    yb = trunc64(yb_raw);
`ifdef BBOX_WALK_CLIP_EN
    if (xb > 639 * 64) xb = 639 * 64;
    if (yb > 479 * 64) yb = 479 * 64;
`endif
    if (xa > xb || ya > yb) return;
    for (int y = ya; y <= yb; y += 64)
      for (int x = xa; x <= xb; x += 64) begin
        pix_t p;
        p.x = x;
        p.y = y;
        exp_q.push_back(p);
      end
  endtask

  task automatic offer_box(input int xa, input int xb, input int ya, input int yb);
    @(negedge CLK);
    XMIN = 16'(xa);
    XMAX = 16'(xb);
    YMIN = 16'(ya);
    YMAX = 16'(yb);
    BOX_VALID = 1'b1;
    chk("box_ready_idle", 32'(BOX_READY), 32'd1);
    @(negedge CLK);
    BOX_VALID = 1'b0;
    XMIN = 16'($urandom);
    XMAX = 16'($urandom);
    YMIN = 16'($urandom);
    YMAX = 16'($urandom);
  endtask

  task automatic run_box(input int xa, input int xb, input int ya, input int yb,
                         input bit rand_stall, input int stall_beat, input int stall_len);
    int idx, stall_left, cycles, n;
    bit stall_done, rdy;
    build_model(xa, xb, ya, yb);
    n = exp_q.size();
    offer_box(xa, xb, ya, yb);
    if (n == 0) begin
      chk("drop_pulse", 32'(BOX_DROP), 32'd1);
      chk("drop_no_valid", 32'(PIX_VALID), 32'd0);
      chk("drop_ready", 32'(BOX_READY), 32'd1);
      @(negedge CLK);
      chk("drop_one_cycle", 32'(BOX_DROP), 32'd0);
      chk("drop_no_valid2", 32'(PIX_VALID), 32'd0);
      return;
    end
    chk("no_drop", 32'(BOX_DROP), 32'd0);
    idx = 0;
    cycles = 0;
    stall_left = 0;
    stall_done = 1'b0;
    while (idx < n && cycles < 5000) begin
      chk("pix_valid", 32'(PIX_VALID), 32'd1);
      chk("px", 32'(PX), 32'(exp_q[idx].x));
      chk("py", 32'(PY), 32'(exp_q[idx].y));
      chk("pix_last", 32'(PIX_LAST), 32'(idx == n - 1));
      if (idx == stall_beat && !stall_done) begin
        stall_left = stall_len;
        stall_done = 1'b1;
      end
      if (stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end else if (rand_stall) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else begin
        rdy = 1'b1;
      end
      PIX_READY = rdy;
      @(negedge CLK);
      cycles++;
      if (rdy) idx++;
    end
    if (idx < n) chk("walk_timeout", 32'(idx), 32'(n));
    chk("end_valid", 32'(PIX_VALID), 32'd0);
    chk("end_ready", 32'(BOX_READY), 32'd1);
    PIX_READY = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0;
    XMIN = '0;
    XMAX = '0;
    YMIN = '0;
    YMAX = '0;
    BOX_VALID = 1'b0;
    PIX_READY = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_box_ready", 32'(BOX_READY), 32'd0);
    chk("rst_pix_valid", 32'(PIX_VALID), 32'd0);
    chk("rst_pix_last", 32'(PIX_LAST), 32'd0);
    chk("rst_box_drop", 32'(BOX_DROP), 32'd0);
    chk("rst_px", 32'(PX), 32'd0);
    chk("rst_py", 32'(PY), 32'd0);
    RST_N = 1'b1;
    #1;
    chk("post_rst_ready", 32'(BOX_READY), 32'd1);

    run_box(64, 192, 0, 64, 1'b0, -1, 0);
    run_box(320, 320, 320, 320, 1'b0, -1, 0);
    run_box(100, 300, 5, 70, 1'b0, -1, 0);
    run_box(64, 192, 0, 64, 1'b0, 1, 3);
    run_box(256, 128, 0, 0, 1'b0, -1, 0);
    run_box(64, 64, 200, 100, 1'b0, -1, 0);
    run_box(16'hFF80, 16'hFFFF, 16'hFFC0, 16'hFFFF, 1'b0, -1, 0);

    // Reset two beats into a walk, then a fresh box must start from its own origin.
    build_model(64, 192, 0, 64);
    offer_box(64, 192, 0, 64);
    PIX_READY = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_walk_px", 32'(PX), 32'(exp_q[i].x));
      chk("rst_walk_py", 32'(PY), 32'(exp_q[i].y));
      @(negedge CLK);
    end
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    PIX_READY = 1'b0;
    #1;
    chk("midrst_valid", 32'(PIX_VALID), 32'd0);
    chk("midrst_last", 32'(PIX_LAST), 32'd0);
    chk("midrst_ready", 32'(BOX_READY), 32'd1);
    chk("midrst_px", 32'(PX), 32'd0);
    run_box(128, 192, 64, 128, 1'b0, -1, 0);

`ifdef BBOX_WALK_CLIP_EN
    run_box(38720, 41280, 0, 0, 1'b0, -1, 0);
    run_box(41024, 41280, 0, 0, 1'b0, -1, 0);
`endif

    for (int k = 0; k < 30; k++) begin
      int xa, xb, ya, yb;
      xa = int'($urandom_range(0, 65535));
      ya = int'($urandom_range(0, 65535));
      xb = xa + int'($urandom_range(0, 320));
      yb = ya + int'($urandom_range(0, 256));
      if (xb > 65535) xb = 65535;
      if (yb > 65535) yb = 65535;
      if ($urandom_range(0, 5) == 0 && trunc64(xa) > 0)
        xb = int'($urandom_range(0, trunc64(xa) - 1));
      run_box(xa, xb, ya, yb, 1'b1, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
